// File: rtl/seq_round_ctrl.sv
// Round sequencer for the memory game: plays the stored colour sequence on the LEDs,
// then checks the player's presses step by step and pulses round_ok or round_fail.
module seq_round_ctrl #(
    parameter int MAX_LEN        = 16,
    parameter int COLOR_W        = 2,
    parameter int ON_CYCLES      = 4,
    parameter int OFF_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [$clog2(MAX_LEN+1)-1:0] len,
    output logic [$clog2(MAX_LEN)-1:0]   mem_addr,
    input  logic [COLOR_W-1:0]           mem_rdata,
    output logic                         led_on,
    output logic [COLOR_W-1:0]           led_color,
    input  logic                         btn_valid,
    input  logic [COLOR_W-1:0]           btn_color,
    output logic                         busy,
    output logic                         round_ok,
    output logic                         round_fail
);

    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int ADDR_W = $clog2(MAX_LEN);
    localparam int TMAX_A = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TMAX   = (TMAX_A > TIMEOUT_CYCLES) ? TMAX_A : TIMEOUT_CYCLES;
    localparam int TMR_W  = $clog2(TMAX + 1);

    localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(OFF_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHOW_ON,
        ST_SHOW_OFF,
        ST_WAIT_IN,
        ST_OK,
        ST_FAIL
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [LEN_W-1:0]   len_q, len_d;

    logic len_valid;
    logic last_step;

    assign len_valid = (len != '0) && (len <= LEN_MAX);
    // idx is compared in the wider length domain so len_q = MAX_LEN needs no special case
    assign last_step = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        len_d   = len_q;

        case (state_q)
            ST_IDLE: begin
                if (start && len_valid) begin
                    state_d = ST_SHOW_ON;
                    len_d   = len;
                    idx_d   = '0;
                    timer_d = '0;
                end
            end

            ST_SHOW_ON: begin
                if (timer_q == ON_LAST) begin
                    state_d = ST_SHOW_OFF;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            ST_SHOW_OFF: begin
                if (timer_q == OFF_LAST) begin
                    timer_d = '0;
                    if (last_step) begin
                        state_d = ST_WAIT_IN;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_SHOW_ON;
                        idx_d   = idx_q + ADDR_W'(1);
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            // A press is always evaluated first, so it wins over a timeout in the same cycle
            ST_WAIT_IN: begin
                if (btn_valid) begin
                    if (btn_color == mem_rdata) begin
                        if (last_step) begin
                            state_d = ST_OK;
                        end else begin
                            idx_d   = idx_q + ADDR_W'(1);
                            timer_d = '0;
                        end
                    end else begin
                        state_d = ST_FAIL;
                    end
                end else if (timer_q == TO_LAST) begin
                    state_d = ST_FAIL;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            ST_OK, ST_FAIL: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                timer_d = '0;
            end

            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
        end
    end

    // len_q is only meaningful after a start has been accepted, so it carries no reset
    always_ff @(posedge clk) begin
        len_q <= len_d;
    end

    always_comb begin
        mem_addr   = idx_q;
        led_on     = (state_q == ST_SHOW_ON);
        led_color  = led_on ? mem_rdata : '0;
        busy       = (state_q != ST_IDLE);
        round_ok   = (state_q == ST_OK);
        round_fail = (state_q == ST_FAIL);
    end

endmodule

// File: tb/tb_seq_round_ctrl.sv
// Directed bench for seq_round_ctrl: playback timing, correct/wrong entry, timeout and boundaries.
module tb_seq_round_ctrl;

    localparam int MAX_LEN = 16;
    localparam int ON      = 4;
    localparam int OFF     = 2;
    localparam int TO      = 64;
    localparam int STEP    = ON + OFF;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] len;
    logic [3:0] mem_addr;
    logic [1:0] mem_rdata;
    logic       led_on;
    logic [1:0] led_color;
    logic       btn_valid;
    logic [1:0] btn_color;
    logic       busy;
    logic       round_ok;
    logic       round_fail;

    logic [1:0] mem [MAX_LEN];

    int n_vec = 0;
    int n_err = 0;

    assign mem_rdata = mem[mem_addr];

    seq_round_ctrl #(
        .MAX_LEN       (MAX_LEN),
        .COLOR_W       (2),
        .ON_CYCLES     (ON),
        .OFF_CYCLES    (OFF),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .led_on    (led_on),
        .led_color (led_color),
        .btn_valid (btn_valid),
        .btn_color (btn_color),
        .busy      (busy),
        .round_ok  (round_ok),
        .round_fail(round_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_idle(input string tag);
        check({tag, ".busy"},       32'(busy),       32'd0);
        check({tag, ".led_on"},     32'(led_on),     32'd0);
        check({tag, ".led_color"},  32'(led_color),  32'd0);
        check({tag, ".round_ok"},   32'(round_ok),   32'd0);
        check({tag, ".round_fail"}, 32'(round_fail), 32'd0);
        check({tag, ".mem_addr"},   32'(mem_addr),   32'd0);
    endtask

    // Leaves the bench in cycle 1 of the round (start sampled at the edge just crossed)
    task automatic start_round(input logic [4:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic press(input logic [1:0] c);
        btn_valid = 1'b1;
        btn_color = c;
        tick();
        btn_valid = 1'b0;
        btn_color = 2'd0;
    endtask

    initial begin
        logic       exp_on;
        logic [1:0] exp_col;

        mem[0] = 2'd2;
        mem[1] = 2'd0;
        mem[2] = 2'd3;
        mem[3] = 2'd1;
        for (int i = 4; i < MAX_LEN; i++) mem[i] = 2'(i * 3);

        rst       = 1'b1;
        start     = 1'b0;
        len       = 5'd0;
        btn_valid = 1'b0;
        btn_color = 2'd0;
        tick();
        tick();
        chk_idle("reset");
        rst = 1'b0;
        tick();

        // Playback of len=3
        start_round(5'd3);
        for (int c = 1; c <= 18; c++) begin
            exp_on  = ((c - 1) % STEP) < ON;
            exp_col = exp_on ? mem[(c - 1) / STEP] : 2'd0;
            check("pb.led_on",    32'(led_on),    32'(exp_on));
            check("pb.led_color", 32'(led_color), 32'(exp_col));
            check("pb.busy",      32'(busy),      32'd1);
            tick();
        end
        check("wait.led_on",   32'(led_on),   32'd0);
        check("wait.busy",     32'(busy),     32'd1);
        check("wait.mem_addr", 32'(mem_addr), 32'd0);

        // Correct entry with irregular gaps
        tick_n(3);
        press(2'd2);
        check("ok1.mem_addr", 32'(mem_addr), 32'd1);
        check("ok1.round_ok", 32'(round_ok), 32'd0);
        tick_n(10);
        press(2'd0);
        check("ok2.mem_addr", 32'(mem_addr), 32'd2);
        tick_n(20);
        press(2'd3);
        check("ok3.round_ok",   32'(round_ok),   32'd1);
        check("ok3.round_fail", 32'(round_fail), 32'd0);
        tick();
        check("ok4.round_ok", 32'(round_ok), 32'd0);
        check("ok4.busy",     32'(busy),     32'd0);
        check("ok4.mem_addr", 32'(mem_addr), 32'd0);

        // Wrong entry, started in the first IDLE cycle after OK
        start_round(5'd3);
        check("re.busy", 32'(busy), 32'd1);
        tick_n(18);
        press(2'd2);
        press(2'd1);
        check("bad.round_fail", 32'(round_fail), 32'd1);
        check("bad.round_ok",   32'(round_ok),   32'd0);
        tick();
        check("bad2.round_fail", 32'(round_fail), 32'd0);
        check("bad2.busy",       32'(busy),       32'd0);
        check("bad2.mem_addr",   32'(mem_addr),   32'd0);

        // Timeout with no press
        start_round(5'd3);
        tick_n(18);
        tick_n(TO - 1);
        check("to63.round_fail", 32'(round_fail), 32'd0);
        check("to63.busy",       32'(busy),       32'd1);
        tick();
        check("to64.round_fail", 32'(round_fail), 32'd1);
        check("to64.round_ok",   32'(round_ok),   32'd0);
        tick();
        chk_idle("to.idle");

        // Press on the 64th idle cycle wins and restarts the timer
        start_round(5'd3);
        tick_n(18);
        tick_n(TO - 1);
        press(2'd2);
        check("tp.round_fail", 32'(round_fail), 32'd0);
        check("tp.busy",       32'(busy),       32'd1);
        check("tp.mem_addr",   32'(mem_addr),   32'd1);
        tick_n(TO - 1);
        check("tp63.round_fail", 32'(round_fail), 32'd0);
        tick();
        check("tp64.round_fail", 32'(round_fail), 32'd1);
        tick();

        // Illegal lengths are ignored
        start_round(5'd0);
        check("len0.busy", 32'(busy), 32'd0);
        start_round(5'd17);
        check("len17.busy",   32'(busy),   32'd0);
        check("len17.led_on", 32'(led_on), 32'd0);
        tick();

        // start, new len and presses during playback are ignored
        start_round(5'd3);
        tick();
        start     = 1'b1;
        len       = 5'd1;
        btn_valid = 1'b1;
        btn_color = 2'd1;
        tick();
        start     = 1'b0;
        btn_valid = 1'b0;
        btn_color = 2'd0;
        check("ign.busy",       32'(busy),       32'd1);
        check("ign.led_on",     32'(led_on),     32'd1);
        check("ign.round_fail", 32'(round_fail), 32'd0);
        tick_n(4);
        check("ign7.led_on",    32'(led_on),    32'd1);
        check("ign7.mem_addr",  32'(mem_addr),  32'd1);
        check("ign7.led_color", 32'(led_color), 32'(mem[1]));
        tick_n(6);
        check("ign13.led_on",    32'(led_on),    32'd1);
        check("ign13.mem_addr",  32'(mem_addr),  32'd2);
        check("ign13.led_color", 32'(led_color), 32'(mem[2]));
        rst = 1'b1;
        tick();
        chk_idle("ign.rst");
        rst = 1'b0;
        tick();

        // Reset during SHOW_ON of step 1, held two cycles
        start_round(5'd3);
        tick_n(7);
        check("rm.led_on",   32'(led_on),   32'd1);
        check("rm.mem_addr", 32'(mem_addr), 32'd1);
        rst = 1'b1;
        tick();
        chk_idle("rm.rst1");
        tick();
        chk_idle("rm.rst2");
        rst = 1'b0;
        press(2'd2);
        chk_idle("rm.btn1");
        press(2'd1);
        chk_idle("rm.btn2");
        tick();

        // Full-length round
        start_round(5'd16);
        tick_n(16 * STEP);
        check("l16.busy",     32'(busy),     32'd1);
        check("l16.led_on",   32'(led_on),   32'd0);
        check("l16.mem_addr", 32'(mem_addr), 32'd0);
        for (int i = 0; i < MAX_LEN; i++) begin
            press(mem[i]);
            if (i < MAX_LEN - 1) begin
                check("l16.round_ok", 32'(round_ok), 32'd0);
                check("l16.mem_addr", 32'(mem_addr), 32'(i + 1));
                tick();
            end
        end
        check("l16.done_ok",   32'(round_ok),   32'd1);
        check("l16.done_fail", 32'(round_fail), 32'd0);
        tick();
        chk_idle("l16.idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_round_ctrl.md
# seq_round_ctrl

Round sequencer for the memory-game datapath. After the main game FSM has written a new step, it plays the stored colour sequence back on the LEDs with fixed on/off timing. It then collects the player's button presses and compares each one, step by step, against sequence memory. It reports one pass/fail pulse per round, which the game FSM uses as its input-ready/compare result.

## Interface
Parameters:
- MAX_LEN, 16: maximum sequence length; sequence memory depth.
- COLOR_W, 2: width of one colour code.
- ON_CYCLES, 4: cycles each step's LED is lit during playback (≥1).
- OFF_CYCLES, 2: dark gap after each lit step (≥1).
- TIMEOUT_CYCLES, 64: idle cycles allowed between presses before failing (≥1).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a round; sampled only in IDLE.
- len  in  $clog2(MAX_LEN+1)  sequence length, latched when start is accepted.
- mem_addr  out  $clog2(MAX_LEN)  sequence memory read address; always equals step index idx.
- mem_rdata  in  COLOR_W  sequence memory data; combinational read, valid same cycle as mem_addr.
- led_on  out  1  playback LED enable.
- led_color  out  COLOR_W  colour shown; mem_rdata while led_on=1, else 0.
- btn_valid  in  1  single-cycle pulse per player press.
- btn_color  in  COLOR_W  colour of the press, valid with btn_valid.
- busy  out  1  high in every state except IDLE.
- round_ok  out  1  one-cycle pulse: all len presses correct.
- round_fail  out  1  one-cycle pulse: wrong press or timeout.

## Operation
- States: IDLE, SHOW_ON, SHOW_OFF, WAIT_IN, OK, FAIL.
- Registers: state, idx, len_q, timer (phase/timeout counter).
- IDLE, start=1, 1≤len≤MAX_LEN: latch len_q=len, idx=0, timer=0, go to SHOW_ON. If len=0 or len>MAX_LEN, start is ignored and the block stays IDLE.
- SHOW_ON: led_on=1 for ON_CYCLES cycles, then SHOW_OFF with timer cleared.
- SHOW_OFF: led_on=0 for OFF_CYCLES cycles. At the end of the phase:
  - if idx=len_q-1, go to WAIT_IN with idx=0, timer=0;
  - otherwise idx+1 and go to SHOW_ON.
- WAIT_IN:
  - btn_valid=1 and btn_color==mem_rdata: if idx=len_q-1, go to OK; else idx+1, timer=0, stay.
  - btn_valid=1 and mismatch: go to FAIL.
  - btn_valid=0: timer+1. On the TIMEOUT_CYCLES-th consecutive cycle without a press, go to FAIL.
  - A press in the same cycle the timeout would fire is evaluated normally and wins over the timeout.
- OK: round_ok=1 for one cycle, then IDLE (idx=0).
- FAIL: round_fail=1 for one cycle, then IDLE (idx=0).
- Ignored inputs:
  - btn_valid outside WAIT_IN;
  - start outside IDLE;
  - len after it has been latched.
- Counters: timer is wide enough to count to max(ON_CYCLES, OFF_CYCLES, TIMEOUT_CYCLES) without wrap. idx never exceeds len_q-1.

## Timing
- Reset (synchronous): state=IDLE, idx=0, timer=0. Outputs from the next cycle: mem_addr=0, led_on=0, led_color=0, busy=0, round_ok=0, round_fail=0.
- rst has priority over every other input. Asserting it mid-round (any state) aborts the round with no ok/fail pulse.
- start accepted at edge 0: SHOW_ON covers cycles 1..ON_CYCLES and busy=1 from cycle 1.
- Playback length: len_q×(ON_CYCLES+OFF_CYCLES) cycles. WAIT_IN begins the cycle after the last OFF phase.
- Final correct press at cycle n: round_ok=1 in cycle n+1 and busy=0 in cycle n+2.
- Wrong press at cycle n: round_fail=1 in cycle n+1.
- start may be re-accepted in the first IDLE cycle after OK/FAIL.
- round_ok and round_fail are never high together and are never high in IDLE.

## Test plan
(Defaults ON=4, OFF=2, TIMEOUT=64; memory = 2,0,3,1.)
- Reset: hold rst 2 cycles mid-stream → all outputs 0, mem_addr=0; btn_valid pulses in IDLE → no ok/fail pulse.
- Playback, start with len=3 at edge 0:
  - led_on=1 in cycles 1–4, 7–10 and 13–16 with led_color 2, 0, 3;
  - led_on=0 in cycles 5–6, 11–12 and 17–18;
  - WAIT_IN from cycle 19 with mem_addr=0.
- Correct entry: presses 2, 0, 3 at arbitrary gaps under 64 cycles → round_ok exactly one cycle after the third press; busy low the cycle after that.
- Wrong entry: presses 2, then 1 (expected 0) → round_fail one cycle after the second press; no round_ok; mem_addr returns to 0.
- Timeout:
  - no press for 64 cycles in WAIT_IN → round_fail;
  - repeat with a correct press on the 64th cycle → accepted, timer restarts, no fail.
- Boundaries:
  - start with len=0 or len=17 → stays IDLE;
  - start during playback → ignored;
  - rst during SHOW_ON at step 1 → IDLE next cycle, no pulse;
  - len=16 round with all-correct input → round_ok.
